mac_learn_ctrl: RTL and testbench

Initiator-side controller for the 48-bit × 64-entry MAC address CAM. It sits between the frame-forwarding logic and the CAM. For each frame it takes a source/destination MAC pair and does the following:
- searches the destination to return a hit and address;
- searches the source, then refreshes it on a hit or learns it on a miss;
- issues CAM init after reset and periodic aging requests from an internal timer.

---
 rtl/mac_learn_ctrl_if.sv | 40 ++++
 rtl/mac_learn_ctrl.sv | 118 +++++++++++
 tb/tb_mac_learn_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_learn_ctrl_if.sv
// mac_learn_ctrl_if: lookup-side and CAM-side handshake bundle for mac_learn_ctrl.
interface mac_learn_ctrl_if;
    logic        lk_req;
    logic [47:0] lk_src_mac;
    logic [47:0] lk_dst_mac;
    logic        lk_ready;
    logic        lk_ack;
    logic        lk_dst_hit;
    logic [5:0]  lk_dst_addr;
    logic        lk_src_new;
    logic        lk_err;
    logic        cam_init_req;
    logic        cam_init_ack;
    logic        cam_search;
    logic [47:0] cam_content;
    logic        cam_matched;
    logic        cam_mismatched;
    logic [5:0]  cam_match_addr;
    logic        cam_empty;
    logic        cam_wr_req;
    logic        cam_wr_ack;
    logic [5:0]  cam_wr_addr;
    logic        cam_refresh_req;
    logic [5:0]  cam_refresh_addr;
    logic        cam_refresh_ack;
    logic        cam_aging_req;
    logic        cam_aging_ack;
    modport master (
        input  lk_req, lk_src_mac, lk_dst_mac, cam_init_ack, cam_matched, cam_mismatched,
               cam_match_addr, cam_empty, cam_wr_ack, cam_wr_addr, cam_refresh_ack, cam_aging_ack,
        output lk_ready, lk_ack, lk_dst_hit, lk_dst_addr, lk_src_new, lk_err, cam_init_req,
               cam_search, cam_content, cam_wr_req, cam_refresh_req, cam_refresh_addr, cam_aging_req
    );
    modport slave (
        output lk_req, lk_src_mac, lk_dst_mac, cam_init_ack, cam_matched, cam_mismatched,
               cam_match_addr, cam_empty, cam_wr_ack, cam_wr_addr, cam_refresh_ack, cam_aging_ack,
        input  lk_ready, lk_ack, lk_dst_hit, lk_dst_addr, lk_src_new, lk_err, cam_init_req,
               cam_search, cam_content, cam_wr_req, cam_refresh_req, cam_refresh_addr, cam_aging_req
    );
endinterface

// File: rtl/mac_learn_ctrl.sv
// mac_learn_ctrl: per-frame dst search plus src refresh/learn, CAM init and periodic aging.
module mac_learn_ctrl #(
    parameter logic [31:0] AGING_PERIOD = 32'd1000000,
    parameter logic [7:0]  RSP_TIMEOUT  = 8'd16
) (
    input logic              clk,
    input logic              rst,
    mac_learn_ctrl_if.master bus
);
    localparam logic [3:0] INIT  = 4'd0;
    localparam logic [3:0] IDLE  = 4'd1;
    localparam logic [3:0] AGE   = 4'd2;
    localparam logic [3:0] DSRCH = 4'd3;
    localparam logic [3:0] DWAIT = 4'd4;
    localparam logic [3:0] SSRCH = 4'd5;
    localparam logic [3:0] SWAIT = 4'd6;
    localparam logic [3:0] WRITE = 4'd7;
    localparam logic [3:0] REFR  = 4'd8;
    localparam logic [3:0] DONE  = 4'd9;
    logic [3:0]  r_state;
    logic        r_go;
    logic [47:0] r_src;
    logic [47:0] r_dst;
    logic [7:0]  r_tmo;
    logic [31:0] r_timer;
    logic        r_age_pend;
    logic        r_seen_low;
    logic        r_hit;
    logic [5:0]  r_haddr;
    logic [5:0]  r_refr_addr;
    logic        r_dst_hit;
    logic [5:0]  r_dst_addr;
    logic        r_src_new;
    logic        r_err;
    logic [3:0]  w_next;
    logic        w_resp;
    logic        w_tmo;
    logic        w_accept;
    logic        w_expire;
    assign w_resp   = bus.cam_matched | bus.cam_mismatched;
    assign w_tmo    = r_tmo == RSP_TIMEOUT - 8'd1;
    assign w_accept = r_state == IDLE && !r_age_pend && bus.lk_req && r_seen_low;
    assign w_expire = r_state != INIT && r_timer == AGING_PERIOD - 32'd1;
    // r_go keeps cam_init_req low until the first edge after reset release
    assign bus.cam_init_req     = r_state == INIT && r_go;
    assign bus.lk_ready         = r_state == IDLE && !r_age_pend;
    assign bus.lk_ack           = r_state == DONE;
    assign bus.cam_search       = r_state == DSRCH || r_state == SSRCH;
    assign bus.cam_content      = r_state == DSRCH ? r_dst : (r_state == SSRCH || r_state == WRITE) ? r_src : 48'd0;
    assign bus.cam_wr_req       = r_state == WRITE;
    assign bus.cam_refresh_req  = r_state == REFR;
    assign bus.cam_refresh_addr = r_refr_addr;
    assign bus.cam_aging_req    = r_state == AGE;
    assign bus.lk_dst_hit       = r_dst_hit;
    assign bus.lk_dst_addr      = r_dst_addr;
    assign bus.lk_src_new       = r_src_new;
    assign bus.lk_err           = r_err;
    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT:    w_next = (r_go && bus.cam_init_ack) ? IDLE : INIT;
            IDLE:    w_next = r_age_pend ? AGE : w_accept ? DSRCH : IDLE;
            AGE:     w_next = bus.cam_aging_ack ? IDLE : AGE;
            DSRCH:   w_next = DWAIT;
            DWAIT:   w_next = (w_resp || w_tmo) ? SSRCH : DWAIT;
            SSRCH:   w_next = SWAIT;
            SWAIT:   w_next = bus.cam_matched ? REFR : bus.cam_mismatched ? (bus.cam_empty ? WRITE : DONE) : w_tmo ? DONE : SWAIT;
            WRITE:   w_next = bus.cam_wr_ack ? DONE : WRITE;
            REFR:    w_next = bus.cam_refresh_ack ? DONE : REFR;
            DONE:    w_next = IDLE;
            default: w_next = INIT;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT;
            r_go        <= 1'b0;
            r_src       <= 48'd0;
            r_dst       <= 48'd0;
            r_tmo       <= 8'd0;
            r_timer     <= 32'd0;
            r_age_pend  <= 1'b0;
            r_seen_low  <= 1'b1;
            r_hit       <= 1'b0;
            r_haddr     <= 6'd0;
            r_refr_addr <= 6'd0;
            r_dst_hit   <= 1'b0;
            r_dst_addr  <= 6'd0;
            r_src_new   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_go    <= 1'b1;
            r_state <= w_next;
            if (w_accept) begin
                r_src <= bus.lk_src_mac;
                r_dst <= bus.lk_dst_mac;
            end
            r_tmo <= (r_state == DWAIT || r_state == SWAIT) ? r_tmo + 8'd1 : 8'd0;
            if (r_state == DWAIT && (w_resp || w_tmo)) begin
                r_hit   <= bus.cam_matched;
                r_haddr <= bus.cam_matched ? bus.cam_match_addr : 6'd0;
            end
            if (r_state == SWAIT && bus.cam_matched)
                r_refr_addr <= bus.cam_match_addr;
            // results are published together so they stay stable from one lk_ack to the next
            if (w_next == DONE && r_state != DONE) begin
                r_dst_hit  <= r_hit;
                r_dst_addr <= r_haddr;
                r_src_new  <= r_state == WRITE;
                r_err      <= r_state == SWAIT;
            end
            r_seen_low <= r_state != DONE && (r_seen_low || !bus.lk_req);
            if (r_state != INIT)
                r_timer <= w_expire ? 32'd0 : r_timer + 32'd1;
            r_age_pend <= w_expire || (r_age_pend && !(r_state == AGE && bus.cam_aging_ack));
        end
    end
endmodule

// File: tb/tb_mac_learn_ctrl.sv
// tb_mac_learn_ctrl: scoreboard bench with a behavioural 64-entry CAM responder.
module tb_mac_learn_ctrl;
    typedef struct packed {logic hit; logic [5:0] addr; logic src_new; logic err;} res_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mac_learn_ctrl_if bus();
    mac_learn_ctrl #(.AGING_PERIOD(32'd100), .RSP_TIMEOUT(8'd16)) dut (.clk(clk), .rst(rst), .bus(bus));
    res_t        sb_q[$];
    int          total = 0, bad = 0, cyc = 0;
    logic        mem_v [64];
    logic [47:0] mem_mac [64];
    int          drop_cnt = 0, wr_count = 0, refr_count = 0, age_cnt = 0;
    int          last_search_cyc = 0, prev_search_cyc = 0, last_age_cyc = 0, prev_age_cyc = 0;
    int          last_ack_cyc = 0, first_srch_cyc = 0;
    logic [47:0] last_wr_mac = 48'd0, rsp_mac = 48'd0;
    logic [5:0]  last_refr_addr = 6'd0;
    bit          rsp_pend = 0, wr_hold = 0, force_full = 0, auto_init = 0, age_prev = 0;
    bit          man_init_ack = 0, auto_ack = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.cam_init_ack = auto_init ? auto_ack : man_init_ack;
    function automatic int find_mac(input logic [47:0] m);
        for (int i = 0; i < 64; i++) if (mem_v[i] && mem_mac[i] == m) return i;
        return -1;
    endfunction
    function automatic int first_free();
        for (int i = 0; i < 64; i++) if (!mem_v[i]) return i;
        return -1;
    endfunction
    // CAM responder: 1-cycle search response, same-cycle acks for write/refresh/aging
    initial begin
        int idx;
        for (int i = 0; i < 64; i++) begin mem_v[i] = 1'b0; mem_mac[i] = 48'd0; end
        bus.cam_matched = 0; bus.cam_mismatched = 0; bus.cam_match_addr = 0; bus.cam_empty = 1;
        bus.cam_wr_ack = 0; bus.cam_wr_addr = 0; bus.cam_refresh_ack = 0; bus.cam_aging_ack = 0;
        forever begin
            @(negedge clk);
            bus.cam_matched = 0; bus.cam_mismatched = 0; bus.cam_wr_ack = 0;
            bus.cam_refresh_ack = 0; bus.cam_aging_ack = 0;
            if (rst) begin
                rsp_pend = 0;
                auto_ack = 0;
            end else begin
                if (rsp_pend) begin
                    idx = find_mac(rsp_mac);
                    if (idx >= 0) begin bus.cam_matched = 1; bus.cam_match_addr = 6'(idx); end
                    else bus.cam_mismatched = 1;
                    rsp_pend = 0;
                end
                if (bus.cam_search) begin
                    prev_search_cyc = last_search_cyc;
                    last_search_cyc = cyc;
                    if (drop_cnt > 0) drop_cnt--;
                    else begin rsp_pend = 1; rsp_mac = bus.cam_content; end
                end
                if (bus.cam_wr_req && !wr_hold) begin
                    idx = first_free();
                    mem_v[idx] = 1'b1; mem_mac[idx] = bus.cam_content;
                    bus.cam_wr_addr = 6'(idx); bus.cam_wr_ack = 1;
                    wr_count++; last_wr_mac = bus.cam_content;
                end
                if (bus.cam_refresh_req) begin
                    bus.cam_refresh_ack = 1; refr_count++; last_refr_addr = bus.cam_refresh_addr;
                end
                if (bus.cam_aging_req) begin
                    bus.cam_aging_ack = 1;
                    if (!age_prev) begin age_cnt++; prev_age_cyc = last_age_cyc; last_age_cyc = cyc; end
                end
                age_prev = bus.cam_aging_req;
                auto_ack = bus.cam_init_req;
                if (auto_init && bus.cam_init_req)
                    for (int i = 0; i < 64; i++) mem_v[i] = 1'b0;
                bus.cam_empty = !force_full && first_free() >= 0;
            end
        end
    end
    task automatic do_lookup(input logic [47:0] src, input logic [47:0] dst, input logic e_hit,
                             input logic [5:0] e_addr, input logic e_new, input logic e_err,
                             input bit chk_lat, input int hold);
        res_t e;
        res_t got;
        int t_srch = -1;
        int extra = 0;
        bit acked = 0;
        sb_q.push_back({e_hit, e_addr, e_new, e_err});
        @(negedge clk);
        bus.lk_src_mac = src; bus.lk_dst_mac = dst; bus.lk_req = 1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.cam_search && t_srch < 0) t_srch = cyc;
            if (bus.lk_ack) begin acked = 1; break; end
        end
        first_srch_cyc = t_srch;
        e = sb_q.pop_front();
        got = {bus.lk_dst_hit, bus.lk_dst_addr, bus.lk_src_new, bus.lk_err};
        total++;
        if (!acked) begin bad++; $display("FAIL lookup_ack src=%h: no lk_ack within 300 cycles", src); end
        else if (got !== e) begin
            bad++;
            $display("FAIL lookup_result src=%h: got hit=%b addr=%0d new=%b err=%b, want hit=%b addr=%0d new=%b err=%b",
                     src, got.hit, got.addr, got.src_new, got.err, e.hit, e.addr, e.src_new, e.err);
        end
        if (acked && chk_lat) begin
            total++;
            if (cyc - t_srch + 1 != 6) begin bad++; $display("FAIL lookup_latency got %0d want 6", cyc - t_srch + 1); end
        end
        last_ack_cyc = cyc;
        for (int n = 0; n < hold; n++) begin
            @(negedge clk);
            if (bus.lk_ack || bus.cam_search) extra++;
        end
        if (hold > 0) begin
            total++;
            if (extra != 0) begin bad++; $display("FAIL level_hold got %0d extra events want 0", extra); end
        end
        bus.lk_req = 0;
        @(negedge clk);
        total++;
        if (bus.lk_dst_hit !== e.hit || bus.lk_dst_addr !== e.addr) begin
            bad++; $display("FAIL result_held got hit=%b addr=%0d want hit=%b addr=%0d", bus.lk_dst_hit, bus.lk_dst_addr, e.hit, e.addr);
        end
    endtask
    task automatic test_reset();
        int cnt = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.lk_ready, bus.lk_ack, bus.cam_init_req, bus.cam_search, bus.cam_wr_req, bus.cam_refresh_req,
             bus.cam_aging_req, bus.lk_dst_hit, bus.lk_src_new, bus.lk_err} !== 10'd0 || bus.cam_content !== 48'd0) begin
            bad++; $display("FAIL reset_outputs: some output nonzero during reset");
        end
        rst = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (n == 0) begin
                total++;
                if (bus.cam_init_req !== 1'b1) begin bad++; $display("FAIL init_first got %b want 1", bus.cam_init_req); end
            end
            if (!bus.cam_init_req && cnt > 0) break;
            if (bus.cam_init_req) cnt++;
            man_init_ack = (cnt == 6);
        end
        man_init_ack = 0;
        total++;
        if (cnt != 6) begin bad++; $display("FAIL init_len got %0d want 6", cnt); end
        total++;
        if (bus.lk_ready !== 1'b1) begin bad++; $display("FAIL ready_after_init got %b want 1", bus.lk_ready); end
    endtask
    task automatic test_learn();
        do_lookup(48'h1, 48'h2, 0, 6'd0, 1, 0, 1, 0);
        total++;
        if (wr_count != 1 || last_wr_mac !== 48'h1) begin
            bad++; $display("FAIL learn_write got count=%0d mac=%h want 1 %h", wr_count, last_wr_mac, 48'h1);
        end
        total++;
        if (bus.lk_ready !== 1'b1) begin bad++; $display("FAIL ready_after_ack got %b want 1", bus.lk_ready); end
    endtask
    task automatic test_hit();
        int r0 = refr_count;
        mem_v[1] = 1'b1; mem_mac[1] = 48'h2;
        do_lookup(48'h1, 48'h2, 1, 6'd1, 0, 0, 1, 0);
        total++;
        if (refr_count != r0 + 1 || last_refr_addr !== 6'd0) begin
            bad++; $display("FAIL refresh got count=%0d addr=%0d want %0d 0", refr_count - r0, last_refr_addr, 1);
        end
    endtask
    task automatic test_back_to_back();
        do_lookup(48'h1, 48'h2, 1, 6'd1, 0, 0, 0, 12);
        do_lookup(48'h1, 48'h2, 1, 6'd1, 0, 0, 1, 0);
    endtask
    task automatic test_timeout();
        drop_cnt = 1;
        do_lookup(48'h30, 48'h77, 0, 6'd0, 1, 0, 0, 0);
        total++;
        if (last_search_cyc - prev_search_cyc != 17) begin
            bad++; $display("FAIL dst_timeout got gap %0d want 17", last_search_cyc - prev_search_cyc);
        end
    endtask
    task automatic test_full();
        int w0 = wr_count;
        force_full = 1;
        do_lookup(48'h40, 48'h2, 1, 6'd1, 0, 1, 0, 0);
        force_full = 0;
        total++;
        if (wr_count != w0) begin bad++; $display("FAIL full_no_write got %0d writes want 0", wr_count - w0); end
    endtask
    task automatic test_aging();
        int c0 = age_cnt;
        int ack1;
        bit got = 0;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            if (age_cnt != c0) begin got = 1; break; end
        end
        total++;
        if (!got) begin bad++; $display("FAIL aging_seen got none want 1 within 150 cycles"); end
        c0 = age_cnt;
        repeat (310) @(negedge clk);
        total++;
        if (age_cnt - c0 != 3) begin bad++; $display("FAIL aging_count got %0d want 3", age_cnt - c0); end
        total++;
        if (last_age_cyc - prev_age_cyc != 100) begin
            bad++; $display("FAIL aging_period got %0d want 100", last_age_cyc - prev_age_cyc);
        end
        while (cyc < last_age_cyc + 80) @(negedge clk);
        drop_cnt = 2;
        do_lookup(48'h60, 48'h61, 0, 6'd0, 0, 1, 0, 0);
        total++;
        if (bus.lk_ready !== 1'b0) begin bad++; $display("FAIL aging_pending_ready got %b want 0", bus.lk_ready); end
        ack1 = last_ack_cyc;
        do_lookup(48'h1, 48'h2, 1, 6'd1, 0, 0, 0, 0);
        total++;
        if (!(last_age_cyc > ack1 && last_age_cyc < first_srch_cyc)) begin
            bad++; $display("FAIL aging_order got age@%0d want between %0d and %0d", last_age_cyc, ack1, first_srch_cyc);
        end
    endtask
    task automatic test_reset_write();
        bit seen = 0;
        int acks = 0;
        wr_hold = 1;
        @(negedge clk);
        bus.lk_src_mac = 48'h55; bus.lk_dst_mac = 48'h2; bus.lk_req = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.cam_wr_req) begin seen = 1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL write_reached got 0 want cam_wr_req=1"); end
        rst = 1;
        #1;
        total++;
        if ({bus.cam_wr_req, bus.cam_search, bus.lk_ack, bus.cam_init_req} !== 4'b0) begin
            bad++; $display("FAIL async_drop got wr=%b srch=%b ack=%b init=%b want 0", bus.cam_wr_req, bus.cam_search, bus.lk_ack, bus.cam_init_req);
        end
        bus.lk_req = 0;
        for (int n = 0; n < 4; n++) begin @(negedge clk); if (bus.lk_ack) acks++; end
        auto_init = 1; wr_hold = 0; rst = 0;
        seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.lk_ack) acks++;
            if (bus.lk_ready) begin seen = 1; break; end
        end
        total++;
        if (acks != 0) begin bad++; $display("FAIL abandoned_ack got %0d want 0", acks); end
        total++;
        if (!seen) begin bad++; $display("FAIL reinit_ready got 0 want 1"); end
        do_lookup(48'h55, 48'h2, 0, 6'd0, 1, 0, 1, 0);
    endtask
    initial begin
        bus.lk_req = 0; bus.lk_src_mac = 48'd0; bus.lk_dst_mac = 48'd0;
        test_reset();
        test_learn();
        test_hit();
        test_back_to_back();
        test_timeout();
        test_full();
        test_aging();
        test_reset_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
